state_decode: RTL and testbench
===============================

# state_decode

Receive-side decoder for the 3-bit light-state sequence produced by the traffic state sequencer. Samples the sequencer's `data` bus on each step strobe and classifies every step as forward (M=1 table), reverse (M=0 table), ambiguous or illegal. From this it recovers the sequencer's mode bit, reports lock, and counts protocol errors. Sits on the display/monitor side of the sequencer and runs on the system clock, faster than the step rate.

## Interface
Parameters:
- LOCK_CNT, 2, consecutive agreeing unambiguous steps required to lock; legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- CR  in  1  asynchronous, active-low reset.
- tick  in  1  one-cycle sample strobe, high once per sequencer step.
- data_in  in  3  sequencer state bus.
- M_out  out  1  recovered mode; meaningful only while locked=1.
- locked  out  1  mode is established.
- mode_chg  out  1  one-cycle pulse: locked mode reversed.
- err  out  1  one-cycle pulse: illegal step detected.
- err_cnt  out  8  illegal-step count, saturating.
- cur_state  out  3  last sampled data_in.

## Operation
- Step tables, prev -> next:
  - Forward (M=1): 000->110, 001->011, 010->110, 011->010, 100->101, 101->001, 110->100, 111->000.
  - Reverse (M=0): 000->110, 001->101, 010->011, 011->001, 100->110, 101->100, 110->010, 111->000.
- Classification of sample n against prev p, only on tick=1:
  - n==111: resync.
  - n matches both tables (p is 000 or 111): ambiguous.
  - n matches exactly one table: unambiguous, with direction d.
  - Otherwise, including n==p: illegal.
- States:
  - IDLE, reset state: first tick loads prev=n and moves to TRACK; nothing is classified.
  - TRACK:
    - Unambiguous step with d == cand: cnt+1. Unambiguous step with d != cand: cand=d, cnt=1.
    - When cnt reaches LOCK_CNT: go to LOCK, M_out=cand, locked=1.
    - Ambiguous step: cnt unchanged.
  - LOCK:
    - Step agreeing with M_out, or ambiguous: no change.
    - Opposite unambiguous step: M_out inverts, mode_chg pulses, stays in LOCK.
- Any state except IDLE:
  - Illegal step: err pulse, err_cnt+1 saturating at 255, cnt=0, go to TRACK, locked=0. M_out holds its value.
  - Resync (n==111): go to TRACK, cnt=0, locked=0. No err.
- prev/cur_state is updated to n on every tick, whatever the classification.
- tick=0: all state holds; err and mode_chg are low.
- err_cnt clears only on reset.

## Timing
- All outputs are registered and update on the clk edge that samples tick=1. Pulses are high for exactly the following cycle.
- Reset values: M_out=0, locked=0, mode_chg=0, err=0, err_cnt=0, cur_state=111, FSM=IDLE, cnt=0, cand=0.
- CR low clears everything immediately, without waiting for clk, including mid-lock. The first tick after release is treated as an IDLE load.
- Lock latency from a sequencer reset, LOCK_CNT=2, M=1: ticks 111,000,110,100,101. locked rises after the 5th tick edge.
- Back-to-back ticks on consecutive cycles are fully supported, with no dead cycles.
- A tick in the same cycle as a state-changing event is just a normal sample; no extra cases exist.

## Test plan
- Reset, then ticks 111,000,110,100,101,001 -> locked=1 and M_out=1 after the 5th tick; err_cnt=0; cur_state=001.
- Reset, then ticks 111,000,110,010,011,001 -> locked=1 and M_out=0 after the 5th tick; mode_chg never pulses.
- Locked at M=1 on 100,101, then tick 100 (reverse from 101) -> M_out=0, one-cycle mode_chg pulse, locked stays 1.
- Locked, then tick with data_in repeated (101,101) -> err pulses once, err_cnt=1, locked=0. Two further agreeing steps relock.
- Inject 300 illegal steps -> err_cnt saturates at 255. Mid-stream 111 sample -> locked=0 with no err. CR low mid-lock -> all outputs return to reset values asynchronously.
- LOCK_CNT=1 build: a single unambiguous step after IDLE -> locked on that tick; ticks spaced with idle cycles give the same results as back-to-back ticks.

Source files
------------

// File: rtl/state_decode.sv
// Receive-side decoder for the traffic sequencer state bus.
// Recovers the sequencer mode bit, reports lock and counts illegal steps.
module state_decode #(
    parameter int LOCK_CNT = 2
) (
    input  logic       clk,
    input  logic       CR,
    input  logic       tick,
    input  logic [2:0] data_in,
    output logic       M_out,
    output logic       locked,
    output logic       mode_chg,
    output logic       err,
    output logic [7:0] err_cnt,
    output logic [2:0] cur_state
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] TRACK = 2'd1;
    localparam logic [1:0] LOCK  = 2'd2;

    logic [1:0] state;
    logic [3:0] cnt;
    logic       cand;

    logic [2:0] fn;
    logic [2:0] rn;
    logic       hit_f;
    logic       hit_r;
    logic       resync;
    logic       illegal;
    logic       uni;
    logic       dir;
    logic [3:0] cnt_nx;

    // Expected successors of the previous sample in each direction
    always_comb begin
        fn = 3'b000;
        rn = 3'b000;
        unique case (cur_state)
            3'b000: begin fn = 3'b110; rn = 3'b110; end
            3'b001: begin fn = 3'b011; rn = 3'b101; end
            3'b010: begin fn = 3'b110; rn = 3'b011; end
            3'b011: begin fn = 3'b010; rn = 3'b001; end
            3'b100: begin fn = 3'b101; rn = 3'b110; end
            3'b101: begin fn = 3'b001; rn = 3'b100; end
            3'b110: begin fn = 3'b100; rn = 3'b010; end
            3'b111: begin fn = 3'b000; rn = 3'b000; end
        endcase
    end

    assign hit_f   = (data_in == fn);
    assign hit_r   = (data_in == rn);
    assign resync  = (data_in == 3'b111);
    assign illegal = !resync && !hit_f && !hit_r;
    assign uni     = !resync && (hit_f ^ hit_r);
    assign dir     = hit_f;
    assign cnt_nx  = (dir == cand) ? cnt + 4'd1 : 4'd1;

    always_ff @(posedge clk or negedge CR) begin
        if (!CR) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            cand      <= 1'b0;
            M_out     <= 1'b0;
            locked    <= 1'b0;
            mode_chg  <= 1'b0;
            err       <= 1'b0;
            err_cnt   <= 8'd0;
            cur_state <= 3'b111;
        end else begin
            mode_chg <= 1'b0;
            err      <= 1'b0;
            if (tick) begin
                cur_state <= data_in;
                if (state == IDLE) begin
                    state <= TRACK;
                end else if (resync) begin
                    state  <= TRACK;
                    cnt    <= 4'd0;
                    locked <= 1'b0;
                end else if (illegal) begin
                    state  <= TRACK;
                    cnt    <= 4'd0;
                    locked <= 1'b0;
                    err    <= 1'b1;
                    if (err_cnt != 8'hff)
                        err_cnt <= err_cnt + 8'd1;
                end else if (uni) begin
                    if (state == LOCK) begin
                        if (dir != M_out) begin
                            M_out    <= dir;
                            mode_chg <= 1'b1;
                            cand     <= dir;
                        end
                    end else begin
                        cand <= dir;
                        cnt  <= cnt_nx;
                        if (cnt_nx >= 4'(LOCK_CNT)) begin
                            state  <= LOCK;
                            locked <= 1'b1;
                            M_out  <= dir;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_state_decode.sv
// Scoreboard bench for state_decode: LOCK_CNT=2 and LOCK_CNT=1 builds
// driven in parallel, expected responses queued per tick.
module tb_state_decode;

    typedef struct packed {
        logic       chk;
        logic       lk;
        logic       m;
        logic       mc;
        logic       e;
        logic [7:0] ec;
        logic [2:0] cs;
    } exp_t;

    localparam exp_t NB = '0;

    logic       clk = 1'b0;
    logic       CR = 1'b0;
    logic       tick = 1'b0;
    logic [2:0] data_in = 3'b000;

    logic       a_m, a_lk, a_mc, a_e;
    logic [7:0] a_ec;
    logic [2:0] a_cs;
    logic       b_m, b_lk, b_mc, b_e;
    logic [7:0] b_ec;
    logic [2:0] b_cs;

    int   nchk = 0;
    int   nfail = 0;
    int   sidx = 0;
    exp_t qa[$];
    exp_t qb[$];
    logic tick_seen;

    always #5 clk = ~clk;

    state_decode #(.LOCK_CNT(2)) dut_a (
        .clk(clk), .CR(CR), .tick(tick), .data_in(data_in),
        .M_out(a_m), .locked(a_lk), .mode_chg(a_mc), .err(a_e),
        .err_cnt(a_ec), .cur_state(a_cs)
    );

    state_decode #(.LOCK_CNT(1)) dut_b (
        .clk(clk), .CR(CR), .tick(tick), .data_in(data_in),
        .M_out(b_m), .locked(b_lk), .mode_chg(b_mc), .err(b_e),
        .err_cnt(b_ec), .cur_state(b_cs)
    );

    function automatic exp_t E(input logic lk, input logic m,
                               input logic mc, input logic e,
                               input logic [7:0] ec,
                               input logic [2:0] cs);
        exp_t r;
        r.chk = 1'b1;
        r.lk = lk;
        r.m = m;
        r.mc = mc;
        r.e = e;
        r.ec = ec;
        r.cs = cs;
        return r;
    endfunction

    function automatic exp_t got_a();
        return E(a_lk, a_m, a_mc, a_e, a_ec, a_cs);
    endfunction

    function automatic exp_t got_b();
        return E(b_lk, b_m, b_mc, b_e, b_ec, b_cs);
    endfunction

    task automatic cmp(input string nm, input int id,
                       input exp_t ex, input exp_t gt);
        if (ex.chk) begin
            nchk++;
            if (gt !== ex) begin
                nfail++;
                $display("FAIL %s step %0d got lk=%b m=%b mc=%b e=%b ec=%0d cs=%b expected lk=%b m=%b mc=%b e=%b ec=%0d cs=%b",
                         nm, id, gt.lk, gt.m, gt.mc, gt.e, gt.ec, gt.cs,
                         ex.lk, ex.m, ex.mc, ex.e, ex.ec, ex.cs);
            end
        end
    endtask

    always @(posedge clk or negedge CR) begin
        if (!CR) tick_seen <= 1'b0;
        else     tick_seen <= tick;
    end

    // Monitor: one queued response per sampled tick; pulses low otherwise
    always @(negedge clk) begin
        if (tick_seen) begin
            if (qa.size() == 0 || qb.size() == 0) begin
                nchk++;
                nfail++;
                $display("FAIL scoreboard_empty at step %0d", sidx);
            end else begin
                cmp("A", sidx, qa.pop_front(), got_a());
                cmp("B", sidx, qb.pop_front(), got_b());
            end
            sidx++;
        end else if (CR) begin
            nchk++;
            if (a_mc || a_e || b_mc || b_e) begin
                nfail++;
                $display("FAIL pulse_low got a_mc=%b a_e=%b b_mc=%b b_e=%b expected 0",
                         a_mc, a_e, b_mc, b_e);
            end
        end
    end

    // Called at posedge+2; leaves control at posedge+2
    task automatic step(input logic [2:0] d, input exp_t ea,
                        input exp_t eb, input int gap);
        tick = 1'b1;
        data_in = d;
        qa.push_back(ea);
        qb.push_back(eb);
        @(posedge clk);
        #2;
        tick = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic check_reset(input string nm);
        cmp({nm, "_A"}, -1, E(0, 0, 0, 0, 8'd0, 3'b111), got_a());
        cmp({nm, "_B"}, -1, E(0, 0, 0, 0, 8'd0, 3'b111), got_b());
    endtask

    task automatic do_reset(input string nm);
        @(negedge clk);
        #3;
        CR = 1'b0;
        #1;
        check_reset(nm);
        @(posedge clk);
        #2;
        CR = 1'b1;
    endtask

    initial begin
        #12;
        check_reset("por");
        @(posedge clk);
        #2;
        CR = 1'b1;

        // Forward lock, LOCK_CNT=2
        step(3'b111, E(0, 0, 0, 0, 0, 3'b111), NB, 0);
        step(3'b000, E(0, 0, 0, 0, 0, 3'b000), NB, 0);
        step(3'b110, E(0, 0, 0, 0, 0, 3'b110), NB, 0);
        step(3'b100, E(0, 0, 0, 0, 0, 3'b100), NB, 0);
        step(3'b101, E(1, 1, 0, 0, 0, 3'b101), NB, 0);
        step(3'b001, E(1, 1, 0, 0, 0, 3'b001), NB, 0);
        step(3'b011, E(1, 1, 0, 0, 0, 3'b011), NB, 0);
        step(3'b010, E(1, 1, 0, 0, 0, 3'b010), NB, 0);
        step(3'b110, E(1, 1, 0, 0, 0, 3'b110), NB, 0);
        step(3'b100, E(1, 1, 0, 0, 0, 3'b100), NB, 1);
        step(3'b101, E(1, 1, 0, 0, 0, 3'b101), NB, 0);
        // Reverse step while locked
        step(3'b100, E(1, 0, 1, 0, 0, 3'b100), NB, 0);
        step(3'b110, E(1, 0, 0, 0, 0, 3'b110), NB, 0);
        // Repeated sample is illegal, then relock
        step(3'b110, E(0, 0, 0, 1, 8'd1, 3'b110), NB, 0);
        step(3'b010, E(0, 0, 0, 0, 8'd1, 3'b010), NB, 0);
        step(3'b011, E(1, 0, 0, 0, 8'd1, 3'b011), NB, 0);
        // Resync drops lock without err
        step(3'b111, E(0, 0, 0, 0, 8'd1, 3'b111), NB, 0);
        step(3'b000, E(0, 0, 0, 0, 8'd1, 3'b000), NB, 0);
        step(3'b110, E(0, 0, 0, 0, 8'd1, 3'b110), NB, 0);
        // Saturate the error counter
        for (int i = 0; i < 300; i++) begin
            int ce;
            ce = (i + 2 > 255) ? 255 : i + 2;
            step(3'b110, E(0, 0, 0, 1, 8'(ce), 3'b110), NB, 0);
        end
        step(3'b100, E(0, 0, 0, 0, 8'd255, 3'b100), NB, 0);
        step(3'b101, E(1, 1, 0, 0, 8'd255, 3'b101), NB, 0);
        do_reset("midlock");

        // Reverse lock from a sequencer reset
        step(3'b111, E(0, 0, 0, 0, 0, 3'b111), NB, 0);
        step(3'b000, E(0, 0, 0, 0, 0, 3'b000), NB, 0);
        step(3'b110, E(0, 0, 0, 0, 0, 3'b110), NB, 0);
        step(3'b010, E(0, 0, 0, 0, 0, 3'b010), NB, 0);
        step(3'b011, E(1, 0, 0, 0, 0, 3'b011), NB, 0);
        step(3'b001, E(1, 0, 0, 0, 0, 3'b001), NB, 0);

        // LOCK_CNT=1 against LOCK_CNT=2, back-to-back and spaced
        for (int g = 0; g < 4; g += 3) begin
            do_reset("b_phase");
            step(3'b111, E(0, 0, 0, 0, 0, 3'b111),
                 E(0, 0, 0, 0, 0, 3'b111), g);
            step(3'b000, E(0, 0, 0, 0, 0, 3'b000),
                 E(0, 0, 0, 0, 0, 3'b000), g);
            step(3'b110, E(0, 0, 0, 0, 0, 3'b110),
                 E(0, 0, 0, 0, 0, 3'b110), g);
            step(3'b100, E(0, 0, 0, 0, 0, 3'b100),
                 E(1, 1, 0, 0, 0, 3'b100), g);
            step(3'b101, E(1, 1, 0, 0, 0, 3'b101),
                 E(1, 1, 0, 0, 0, 3'b101), g);
        end

        @(negedge clk);
        #1;
        nchk++;
        if (qa.size() != 0) begin
            nfail++;
            $display("FAIL drain got %0d pending expected 0", qa.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 nchk, nfail);
        $finish;
    end

endmodule
